// File: rtl/fft_pkg.sv
// Shared FFT sequencing types and frame-size constants.
package fft_pkg;

    // Default log2 of blocks per frame (one block = 16 complex samples per clock)
    localparam int FFT_CLK_CNT       = 5;
    localparam int FFT_BLK_PER_FRAME = 2 ** FFT_CLK_CNT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fft_state_e;

endpackage

// File: rtl/counter.sv
// Generic wrapping up-counter with synchronous clear and count enable.
module counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Clear wins over enable; the counter wraps naturally modulo 2^W
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/fft_twd_sched.sv
// Sequencer for the pipelined radix-2 FFT: turns din_valid into per-stage
// butterfly/twiddle enables, keeps per-stage block counters for twiddle
// rotation select, and flags frame start, last output and busy.
module fft_twd_sched
    import fft_pkg::*;
#(
    parameter int NSTG    = 3,
    parameter int CLK_CNT = FFT_CLK_CNT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    soft_clr,
    input  logic                    din_valid,
    output logic [NSTG-1:0]         bfly_valid,
    output logic [NSTG-1:0]         twd_valid,
    output logic [NSTG*CLK_CNT-1:0] twd_cnt,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    frame_start,
    output logic                    busy,
    output logic [1:0]              state
);

    // Tap 2s feeds butterfly s, tap 2s+1 feeds twiddle s, top tap is the output
    localparam int CHAIN_W = 2 * NSTG + 1;

    logic [CHAIN_W-1:0] r_vchain;
    logic [CLK_CNT-1:0] w_in_cnt;
    logic [CLK_CNT-1:0] w_out_cnt;
    fft_state_e         r_state;
    fft_state_e         w_state_nxt;
    logic               r_busy;
    logic               w_in_last;
    logic               w_out_max;
    logic               w_chain_rest;

    // Valid delay line: bubbles travel with the data, so there is no stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vchain <= '0;
        end else if (soft_clr) begin
            r_vchain <= '0;
        end else begin
            r_vchain <= {r_vchain[CHAIN_W-2:0], din_valid};
        end
    end

    // Per-stage enables and twiddle block counters
    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        assign bfly_valid[s] = r_vchain[2*s];
        assign twd_valid[s]  = r_vchain[2*s+1];

        counter #(.W(CLK_CNT)) u_twd_cnt (
            .clk  (clk),
            .rstn (rstn),
            .clr  (soft_clr),
            .en   (r_vchain[2*s+1]),
            .cnt  (twd_cnt[s*CLK_CNT +: CLK_CNT])
        );
    end

    assign out_valid = r_vchain[CHAIN_W-1];

    counter #(.W(CLK_CNT)) u_in_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (soft_clr),
        .en   (din_valid),
        .cnt  (w_in_cnt)
    );

    counter #(.W(CLK_CNT)) u_out_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (soft_clr),
        .en   (out_valid),
        .cnt  (w_out_cnt)
    );

    assign w_in_last    = (w_in_cnt == {CLK_CNT{1'b1}});
    assign w_out_max    = (w_out_cnt == {CLK_CNT{1'b1}});
    assign w_chain_rest = |r_vchain[CHAIN_W-2:0];

    // A din_valid is only accepted outside reset and when not being cleared
    assign frame_start = rstn & ~soft_clr & din_valid & (w_in_cnt == '0);
    assign out_last    = out_valid & w_out_max;

    // Next-state: a new frame may start while the previous one drains
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (din_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (din_valid && w_in_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (din_valid) begin
                    w_state_nxt = RUN;
                end else if (out_last && !w_chain_rest) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (soft_clr) begin
            w_state_nxt = IDLE;
        end
    end

    // State register, with busy registered alongside it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign state = r_state;
    assign busy  = r_busy;

endmodule

// File: tb/tb_fft_twd_sched.sv
// Directed bench for fft_twd_sched: reset, single/gapped/back-to-back frames,
// overlapping frames and mid-frame abort.
module tb_fft_twd_sched;

    localparam int NSTG    = 3;
    localparam int CLK_CNT = 5;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic                    clk;
    logic                    rstn;
    logic                    soft_clr;
    logic                    din_valid;
    logic [NSTG-1:0]         bfly_valid;
    logic [NSTG-1:0]         twd_valid;
    logic [NSTG*CLK_CNT-1:0] twd_cnt;
    logic                    out_valid;
    logic                    out_last;
    logic                    frame_start;
    logic                    busy;
    logic [1:0]              state;

    fft_twd_sched #(.NSTG(NSTG), .CLK_CNT(CLK_CNT)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .soft_clr    (soft_clr),
        .din_valid   (din_valid),
        .bfly_valid  (bfly_valid),
        .twd_valid   (twd_valid),
        .twd_cnt     (twd_cnt),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .frame_start (frame_start),
        .busy        (busy),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int ov_n;
    int last_q[$];
    int fs_q[$];
    logic               hist    [256];
    logic [1:0]         st_hist [256];
    logic [CLK_CNT-1:0] tc0_hist[256];
    logic [CLK_CNT-1:0] exp_tc  [NSTG];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic h(input int i);
        if (i < 0) return 1'b0;
        return hist[i];
    endfunction

    function automatic int qrd(input int q[$], input int i);
        if (q.size() > i) return q[i];
        return -1;
    endfunction

    task automatic phase_start();
        cyc  = 0;
        ov_n = 0;
        last_q.delete();
        fs_q.delete();
        for (int i = 0; i < 256; i++) begin
            hist[i]     = 1'b0;
            st_hist[i]  = 2'd3;
            tc0_hist[i] = '0;
        end
    endtask

    // One cycle: drive at negedge, sample 1 time unit later, check the valid
    // chain delays and the stage counters against the bench's expectation.
    task automatic step(input logic dv, input logic clr);
        logic [NSTG-1:0]         eb;
        logic [NSTG-1:0]         et;
        logic                    eo;
        logic [NSTG*CLK_CNT-1:0] etc_p;
        @(negedge clk);
        din_valid = dv;
        soft_clr  = clr;
        hist[cyc] = dv;
        #1;
        for (int s = 0; s < NSTG; s++) begin
            eb[s] = h(cyc - 1 - 2*s);
            et[s] = h(cyc - 2 - 2*s);
            etc_p[s*CLK_CNT +: CLK_CNT] = exp_tc[s];
        end
        eo = h(cyc - 1 - 2*NSTG);
        chk("chain", {25'd0, bfly_valid, twd_valid, out_valid}, {25'd0, eb, et, eo});
        chk("twd_cnt", {17'd0, twd_cnt}, {17'd0, etc_p});
        st_hist[cyc]  = state;
        tc0_hist[cyc] = twd_cnt[CLK_CNT-1:0];
        if (out_valid)   ov_n++;
        if (out_last)    last_q.push_back(cyc);
        if (frame_start) fs_q.push_back(cyc);
        for (int s = 0; s < NSTG; s++) begin
            if (et[s]) exp_tc[s] = exp_tc[s] + 1'b1;
        end
        cyc++;
        if (clr) begin
            for (int s = 0; s < NSTG; s++) exp_tc[s] = '0;
            phase_start();
        end
    endtask

    initial begin
        logic ok;
        rstn      = 1'b0;
        soft_clr  = 1'b0;
        din_valid = 1'b1;
        for (int s = 0; s < NSTG; s++) exp_tc[s] = '0;
        phase_start();

        // Reset held with din_valid high
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bfly", {29'd0, bfly_valid}, 32'd0);
        chk("rst_twd", {29'd0, twd_valid}, 32'd0);
        chk("rst_twdcnt", {17'd0, twd_cnt}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        @(negedge clk);
        rstn      = 1'b1;
        din_valid = 1'b0;

        // First valid after release
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("first_bfly", {29'd0, bfly_valid}, 32'd1);
        chk("first_state", {30'd0, state}, {30'd0, S_RUN});
        chk("first_busy", {31'd0, busy}, 32'd1);
        chk("first_fs", qrd(fs_q, 0), 32'd0);
        repeat (8) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Single contiguous frame
        for (int c = 0; c < 32; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
        chk("sf_st0", {30'd0, st_hist[0]}, {30'd0, S_IDLE});
        chk("sf_blk15_top", {31'd0, tc0_hist[17][CLK_CNT-1]}, 32'd0);
        chk("sf_blk16", {27'd0, tc0_hist[18]}, 32'd16);
        chk("sf_blk16_top", {31'd0, tc0_hist[18][CLK_CNT-1]}, 32'd1);
        chk("sf_blk31", {27'd0, tc0_hist[33]}, 32'd31);
        chk("sf_ov_n", ov_n, 32'd32);
        chk("sf_last_n", last_q.size(), 32'd1);
        chk("sf_last", qrd(last_q, 0), 32'd38);
        chk("sf_st31", {30'd0, st_hist[31]}, {30'd0, S_RUN});
        chk("sf_st32", {30'd0, st_hist[32]}, {30'd0, S_DRAIN});
        chk("sf_st38", {30'd0, st_hist[38]}, {30'd0, S_DRAIN});
        chk("sf_st39", {30'd0, st_hist[39]}, {30'd0, S_IDLE});
        chk("sf_busy_end", {31'd0, busy}, 32'd0);

        // Gapped frame: valid on even cycles
        phase_start();
        for (int c = 0; c < 64; c++) step((c % 2) == 0, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
        ok = 1'b1;
        for (int c = 1; c <= 62; c++) if (st_hist[c] != S_RUN) ok = 1'b0;
        chk("gp_run_held", {31'd0, ok}, 32'd1);
        chk("gp_ov_n", ov_n, 32'd32);
        chk("gp_last_n", last_q.size(), 32'd1);
        chk("gp_last", qrd(last_q, 0), 32'd69);
        chk("gp_st63", {30'd0, st_hist[63]}, {30'd0, S_DRAIN});
        chk("gp_st70", {30'd0, st_hist[70]}, {30'd0, S_IDLE});

        // Back-to-back frames
        phase_start();
        for (int c = 0; c < 64; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0);
        chk("bb_fs_n", fs_q.size(), 32'd2);
        chk("bb_fs0", qrd(fs_q, 0), 32'd0);
        chk("bb_fs1", qrd(fs_q, 1), 32'd32);
        chk("bb_last0", qrd(last_q, 0), 32'd38);
        chk("bb_last1", qrd(last_q, 1), 32'd70);
        chk("bb_ov_n", ov_n, 32'd64);
        chk("bb_st32", {30'd0, st_hist[32]}, {30'd0, S_DRAIN});
        chk("bb_st33", {30'd0, st_hist[33]}, {30'd0, S_RUN});
        chk("bb_st64", {30'd0, st_hist[64]}, {30'd0, S_DRAIN});
        chk("bb_st71", {30'd0, st_hist[71]}, {30'd0, S_IDLE});

        // Overlap: second frame starts the cycle the first out_last fires
        phase_start();
        for (int c = 0; c < 32; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 6; c++)  step(1'b0, 1'b0);
        for (int c = 0; c < 32; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0);
        ok = 1'b1;
        for (int c = 1; c <= 76; c++) if (st_hist[c] == S_IDLE) ok = 1'b0;
        chk("ov_no_idle", {31'd0, ok}, 32'd1);
        chk("ov_st38", {30'd0, st_hist[38]}, {30'd0, S_DRAIN});
        chk("ov_st39", {30'd0, st_hist[39]}, {30'd0, S_RUN});
        chk("ov_fs1", qrd(fs_q, 1), 32'd38);
        chk("ov_last0", qrd(last_q, 0), 32'd38);
        chk("ov_last1", qrd(last_q, 1), 32'd76);
        chk("ov_st77", {30'd0, st_hist[77]}, {30'd0, S_IDLE});

        // Abort at block 10, then a clean frame
        phase_start();
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("ab_twdcnt", {17'd0, twd_cnt}, 32'd0);
        chk("ab_chain", {25'd0, bfly_valid, twd_valid, out_valid}, 32'd0);
        chk("ab_state", {30'd0, state}, {30'd0, S_IDLE});
        chk("ab_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 32; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
        chk("ab_fs_n", fs_q.size(), 32'd1);
        chk("ab_fs0", qrd(fs_q, 0), 32'd1);
        chk("ab_ov_n", ov_n, 32'd32);
        chk("ab_last", qrd(last_q, 0), 32'd39);
        chk("ab_st40", {30'd0, st_hist[40]}, {30'd0, S_IDLE});

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_twd_sched.md
# fft_twd_sched

Sequencer for the pipelined radix-2 FFT datapath: it turns the input-side `din_valid` strobe into per-stage butterfly and twiddle enables, and keeps a per-stage block counter that the twiddle multipliers use to select their rotation. It also flags frame start, last output and pipeline busy. The block sits between the input sample buffer and the chain of butterfly / twiddle-multiply stages, and has no data path of its own.

## Interface
- `NSTG`, default 3: number of butterfly + twiddle stage pairs sequenced.
- `CLK_CNT`, default 5: log2 of blocks per frame (one block is 16 complex samples per clock); a frame is 2^CLK_CNT valid cycles.
- `clk` input, 1 bit: clock, rising edge.
- `rstn` input, 1 bit: one clock; reset is asynchronous and active-low.
- `soft_clr` input, 1 bit: synchronous clear; same effect as reset on the next edge.
- `din_valid` input, 1 bit: one input block is present this cycle; gaps between blocks are legal.
- `bfly_valid` output, NSTG bits: bit s is the enable for butterfly stage s.
- `twd_valid` output, NSTG bits: bit s is the enable for twiddle stage s.
- `twd_cnt` output, NSTG*CLK_CNT bits: stage s block counter in slice [s*CLK_CNT +: CLK_CNT].
- `out_valid` output, 1 bit: the final stage output register holds a valid block.
- `out_last` output, 1 bit: marks the 2^CLK_CNT-th `out_valid` of a frame.
- `frame_start` output, 1 bit: pulse on the first accepted `din_valid` of a frame.
- `busy` output, 1 bit: high when the FSM is not IDLE.
- `state` output, 2 bits: FSM state for debug (IDLE=0, RUN=1, DRAIN=2).

## Operation
- Valid chain: a shift register of 2*NSTG+1 bits, advanced every cycle.
  - `bfly_valid[s]` = `din_valid` delayed 2s+1 cycles.
  - `twd_valid[s]` = `din_valid` delayed 2s+2 cycles.
  - `out_valid` = the last tap.
  - Bubbles propagate unchanged, so no stall input exists.
- Counters, all CLK_CNT bits, wrapping modulo 2^CLK_CNT:
  - `in_cnt` increments on `din_valid`.
  - `twd_cnt` slice s increments on `twd_valid[s]`.
  - `out_cnt` increments on `out_valid`.
- Each stage counter holds the index of the block currently presented to that stage. The twiddle stage s uses the top s+1 bits of its slice for rotation select; for stage 0 that is a 1-bit value, 0 for the first half of the frame and 1 for the second.
- `frame_start` = `din_valid` && `in_cnt`==0.
- `out_last` = `out_valid` && `out_cnt`==2^CLK_CNT-1.
- FSM transitions:
  - IDLE → RUN on `din_valid`.
  - RUN → DRAIN when `din_valid` && `in_cnt`==max, i.e. the last block of a frame is accepted.
  - DRAIN → RUN on `din_valid`; the next frame overlaps the draining one.
  - DRAIN → IDLE on `out_last` when no other valid bit is set in the chain and `din_valid`=0.
  - The FSM stays in RUN across input gaps.
- Simultaneous events:
  - `out_last` and a new `din_valid` in the same cycle → RUN.
  - `soft_clr` overrides all inputs.
- Reset or `soft_clr` mid-frame aborts the frame. No partial-frame flush is produced; the datapath must be reset together with this block.

## Timing
- Reset values: all outputs 0, `state`=IDLE, all counters 0, valid chain 0.
- All outputs are registered except `frame_start` and `out_last`, which are combinational from registered counters and valid bits (plus `din_valid` for `frame_start`).
- `din_valid` at edge t gives `bfly_valid[0]` at t+1, `twd_valid[0]` at t+2, and `out_valid` at t+2*NSTG+1 (t+7 at default NSTG).
- A stage counter slice changes on the edge after its valid bit is sampled high. Block k of a frame sees slice value k while its `twd_valid` bit is high.
- Back-to-back frames: a 64-cycle contiguous `din_valid` yields two `out_last` pulses exactly 32 cycles apart.

## Structure
- Shared package `fft_pkg`:
  - `fft_state_e` enum (IDLE, RUN, DRAIN).
  - `FFT_BLK_PER_FRAME` = 2**CLK_CNT.
- Reuse the codebase `counter` sub-module, one instance per stage counter and one each for the input and output counters, with enable = the corresponding valid. `soft_clr` is ORed into the counter clear path.
- The valid delay line and FSM are inline.

## Test plan
- Reset check: hold `rstn`=0 with `din_valid`=1 → all outputs 0, `state`=0; release → first `bfly_valid[0]` one cycle after the first sampled `din_valid`.
- Single frame: 32 contiguous `din_valid` → `twd_cnt` slice 0 counts 0..31 and its top bit is 1 for blocks 16..31; `out_last` at cycle 38 after the first valid; then IDLE.
- Gapped frame: `din_valid` alternating 1/0 for 64 cycles → still 32 `out_valid` pulses; `out_last` on the 32nd; the FSM never leaves RUN before the last input block.
- Back-to-back: 64 contiguous valids → two `frame_start` pulses (cycles 0 and 32), two `out_last` pulses 32 cycles apart, DRAIN entered at cycle 31 and again at 63.
- Overlap: second frame starts the cycle the first `out_last` fires → `state` goes DRAIN→RUN, no IDLE cycle.
- Abort: `soft_clr` at block 10 of a frame → next cycle all counters 0 and the chain empty; a new 32-block frame then completes normally.
